pipe_rate_ctrl: RTL

PIPE_RATE_CTRL -- requirements
Module: pipe_rate_ctrl

---
 rtl/pipe_rate_ctrl_if.sv | 31 +++
 rtl/pipe_rate_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_rate_ctrl_if.sv
// pipe_rate_ctrl_if: LTSSM request handshake and PIPE rate-change signals
// bundled for pipe_rate_ctrl. The slave modport is the rate controller; the
// master modport is the LTSSM/PHY side that drives requests and PHY status.
interface pipe_rate_ctrl_if;
    // LTSSM request handshake
    logic       req_valid;
    logic [2:0] req_rate;
    logic       req_ready;
    logic       done;
    logic       error;
    logic [2:0] cur_rate;
    // PIPE side
    logic [3:0] Rate;
    logic [4:0] PCLKRate;
    logic       PclkChangeAck;
    logic       PclkChangeOk;
    logic       PhyStatus;
    logic       eidle_req;

    modport slave (
        input  req_valid, req_rate, PclkChangeOk, PhyStatus,
        output req_ready, done, error, cur_rate, Rate, PCLKRate,
               PclkChangeAck, eidle_req
    );

    modport master (
        output req_valid, req_rate, PclkChangeOk, PhyStatus,
        input  req_ready, done, error, cur_rate, Rate, PCLKRate,
               PclkChangeAck, eidle_req
    );
endinterface

// File: rtl/pipe_rate_ctrl.sv
// pipe_rate_ctrl: sequences a PIPE generation change. An accepted request
// forces electrical idle, drives the new Rate/PCLKRate, waits for the PHY to
// allow the PCLK change, acknowledges it, and commits the new generation once
// PhyStatus reports completion. All outputs are registered: each is computed
// from the next state and loaded on the same edge as the state register.
// Optional feature: define PIPE_RATE_CTRL_TIMEOUT_EN to add a handshake
// timeout (TIMEOUT_CYCLES) covering WAIT_OK and ACK.
module pipe_rate_ctrl #(
    parameter int unsigned MAX_GEN        = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             CLK,
    input  logic             reset,
    pipe_rate_ctrl_if.slave  pif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EIDLE,
        S_WAIT_OK,
        S_ACK,
        S_DONE
    } state_t;

    localparam logic [2:0] MAX_GEN_L = 3'(MAX_GEN);

    // Parameter sanity checks at elaboration time
    if (MAX_GEN < 1 || MAX_GEN > 5) begin : g_bad_max_gen
        $error("pipe_rate_ctrl: MAX_GEN must be in 1..5");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("pipe_rate_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    state_t     state_q, state_d;
    logic [2:0] tgt_q, tgt_d;
    logic [2:0] cur_rate_q, cur_rate_d;
    logic [3:0] rate_q, rate_d;
    logic [4:0] pclk_rate_q, pclk_rate_d;
    logic       ack_q, ack_d;
    logic       eidle_q, eidle_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic       ready_q, ready_d;
    logic [2:0] req_gen_m1;
    logic [2:0] cur_gen_m1;

`ifdef PIPE_RATE_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_hit;
`endif

    assign req_gen_m1 = pif.req_rate - 3'd1;
    assign cur_gen_m1 = cur_rate_q - 3'd1;

`ifdef PIPE_RATE_CTRL_TIMEOUT_EN
    // Handshake timer: cleared while entering WAIT_OK, runs through WAIT_OK and ACK
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == S_WAIT_OK || state_q == S_ACK) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        cur_rate_d  = cur_rate_q;
        rate_d      = rate_q;
        pclk_rate_d = pclk_rate_q;
        ack_d       = 1'b0;
        eidle_d     = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pif.req_valid && ready_q) begin
                    if (pif.req_rate == 3'd0 || pif.req_rate > MAX_GEN_L) begin
                        error_d = 1'b1;
                    end else if (pif.req_rate == cur_rate_q) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_d       = pif.req_rate;
                        state_d     = S_EIDLE;
                        eidle_d     = 1'b1;
                        rate_d      = {1'b0, req_gen_m1};
                        pclk_rate_d = {2'b00, req_gen_m1};
                    end
                end
            end
            S_EIDLE: begin
                state_d = S_WAIT_OK;
                eidle_d = 1'b1;
            end
            S_WAIT_OK: begin
                eidle_d = 1'b1;
                if (pif.PclkChangeOk) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                end
`ifdef PIPE_RATE_CTRL_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d     = S_IDLE;
                    eidle_d     = 1'b0;
                    error_d     = 1'b1;
                    rate_d      = {1'b0, cur_gen_m1};
                    pclk_rate_d = {2'b00, cur_gen_m1};
                end
`endif
            end
            S_ACK: begin
                eidle_d = 1'b1;
                ack_d   = 1'b1;
                if (pif.PhyStatus) begin
                    state_d    = S_DONE;
                    eidle_d    = 1'b0;
                    ack_d      = 1'b0;
                    done_d     = 1'b1;
                    cur_rate_d = tgt_q;
                end
`ifdef PIPE_RATE_CTRL_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d     = S_IDLE;
                    eidle_d     = 1'b0;
                    ack_d       = 1'b0;
                    error_d     = 1'b1;
                    rate_d      = {1'b0, cur_gen_m1};
                    pclk_rate_d = {2'b00, cur_gen_m1};
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // State and output registers with asynchronous reset to Gen1 idle
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tgt_q       <= 3'd1;
            cur_rate_q  <= 3'd1;
            rate_q      <= '0;
            pclk_rate_q <= '0;
            ack_q       <= 1'b0;
            eidle_q     <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            ready_q     <= 1'b1;
`ifdef PIPE_RATE_CTRL_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            cur_rate_q  <= cur_rate_d;
            rate_q      <= rate_d;
            pclk_rate_q <= pclk_rate_d;
            ack_q       <= ack_d;
            eidle_q     <= eidle_d;
            done_q      <= done_d;
            error_q     <= error_d;
            ready_q     <= ready_d;
`ifdef PIPE_RATE_CTRL_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign pif.req_ready     = ready_q;
    assign pif.done          = done_q;
    assign pif.error         = error_q;
    assign pif.cur_rate      = cur_rate_q;
    assign pif.Rate          = rate_q;
    assign pif.PCLKRate      = pclk_rate_q;
    assign pif.PclkChangeAck = ack_q;
    assign pif.eidle_req     = eidle_q;

endmodule
